// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - command/state encodings and JK decode shared by the JK bank arbiter
package jk_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2
  } arb_state_t;

  // Returns {J, K} for a command.
  function automatic logic [1:0] cmd_to_jk(input logic [1:0] c);
    logic [1:0] jk;
    jk = 2'b00;
    case (c)
      CMD_HOLD: jk = 2'b00;
      CMD_RST:  jk = 2'b01;
      CMD_SET:  jk = 2'b10;
      CMD_TGL:  jk = 2'b11;
      default:  jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - W independent JK flip-flops with per-bit enable, async reset to 0
module jk_ff_bank #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] enable,
  input  logic [W-1:0] J,
  input  logic [W-1:0] K,
  output logic [W-1:0] Q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (enable[i]) begin
          case ({J[i], K[i]})
            2'b01:   Q[i] <= 1'b0;
            2'b10:   Q[i] <= 1'b1;
            2'b11:   Q[i] <= ~Q[i];
            default: Q[i] <= Q[i];
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - serialises requester JK commands onto a shared flip-flop bank
// JK_ARB_ROUNDROBIN_EN selects round-robin arbitration; otherwise fixed lowest-index priority.
module jk_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   cmd,
  input  logic [W*NREQ-1:0]   mask,
  output logic [NREQ-1:0]     grant,
  output logic                busy,
  output logic [W-1:0]        Q
);

  import jk_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   sel_q, sel_nxt, pick;
  logic            any_elig;
  logic [NREQ-1:0] elig;
  logic [1:0]      hold_cmd;
  logic [W-1:0]    hold_mask;
  logic [W-1:0]    bank_en, bank_j, bank_k;
  logic [1:0]      jk;

`ifdef JK_ARB_ROUNDROBIN_EN
  logic [IW-1:0] ptr, ptr_nxt;

  // Descending scan so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx      = 0;
    elig     = req;
    if (state == APPLY) elig[sel_q] = 1'b0;
    any_elig = 1'b0;
    pick     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (elig[idx]) begin
        any_elig = 1'b1;
        pick     = IW'(idx);
      end
    end
    ptr_nxt = (int'(pick) == NREQ - 1) ? '0 : pick + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state_nxt == GRANT) begin
      ptr <= ptr_nxt;
    end
  end
`else
  // Without rotation the just-served requester stays eligible, so a held req[0] wins every slot.
  always_comb begin
    elig     = req;
    any_elig = 1'b0;
    pick     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[k]) begin
        any_elig = 1'b1;
        pick     = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    grant     = '0;
    busy      = (state != IDLE);
    bank_en   = '0;
    case (state)
      IDLE: begin
        if (any_elig) begin
          state_nxt = GRANT;
          sel_nxt   = pick;
        end
      end
      GRANT: begin
        grant     = NREQ'(1) << sel_q;
        state_nxt = APPLY;
      end
      APPLY: begin
        bank_en = hold_mask;
        if (any_elig) begin
          state_nxt = GRANT;
          sel_nxt   = pick;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= '0;
      hold_cmd  <= '0;
      hold_mask <= '0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
      if (state == GRANT) begin
        hold_cmd  <= cmd[2*int'(sel_q) +: 2];
        hold_mask <= mask[W*int'(sel_q) +: W];
      end
    end
  end

  assign jk     = cmd_to_jk(hold_cmd);
  assign bank_j = {W{jk[1]}};
  assign bank_k = {W{jk[0]}};

  jk_ff_bank #(.W(W)) u_bank (
    .clk    (clk),
    .rst    (rst),
    .enable (bank_en),
    .J      (bank_j),
    .K      (bank_k),
    .Q      (Q)
  );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - randomized and directed checks of jk_bank_arbiter against a transaction model
module tb_jk_bank_arbiter;
  import jk_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   cmd;
  logic [W*NREQ-1:0]   mask;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic [W-1:0]        q;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .cmd   (cmd),
    .mask  (mask),
    .grant (grant),
    .busy  (busy),
    .Q     (q)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction model: who holds the grant slot, which command is being applied, bank contents.
  int           m_gidx;
  bit           m_apply;
  int           m_last;
  int           m_p;
  logic [1:0]   m_cmd;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_q;
  bit           auto_drop;
  int           cool [NREQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gidx  = -1;
    m_apply = 0;
    m_last  = 0;
    m_p     = 0;
    m_cmd   = '0;
    m_mask  = '0;
    m_q     = '0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] el;
    int w;
    if (m_gidx >= 0) begin
      m_cmd   = cmd[2*m_gidx +: 2];
      m_mask  = mask[W*m_gidx +: W];
      m_last  = m_gidx;
      m_apply = 1;
      m_gidx  = -1;
    end else begin
      el = req;
      if (m_apply) begin
`ifdef JK_ARB_ROUNDROBIN_EN
        el[m_last] = 1'b0;
`endif
        for (int b = 0; b < W; b++) begin
          if (m_mask[b]) begin
            if (m_cmd == CMD_RST) m_q[b] = 1'b0;
            else if (m_cmd == CMD_SET) m_q[b] = 1'b1;
            else if (m_cmd == CMD_TGL) m_q[b] = ~m_q[b];
          end
        end
        m_apply = 0;
      end
      w = -1;
`ifdef JK_ARB_ROUNDROBIN_EN
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && el[(m_p + k) % NREQ]) w = (m_p + k) % NREQ;
      end
`else
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && el[k]) w = k;
      end
`endif
      if (w >= 0) begin
        m_gidx = w;
        m_p    = (w + 1) % NREQ;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("grant", 32'(grant), (m_gidx >= 0) ? (32'd1 << m_gidx) : 32'd0);
    check("busy", 32'(busy), 32'((m_gidx >= 0) || m_apply));
    check("q", 32'(q), 32'(m_q));
    if (auto_drop && m_gidx >= 0) begin
      req[m_gidx]  = 1'b0;
      cool[m_gidx] = 2;
    end
  endtask

  task automatic run_cmd(input int idx, input logic [1:0] c, input logic [W-1:0] m,
                         input logic [W-1:0] expq, input logic [NREQ-1:0] expg, input string tag);
    req[idx]          = 1'b1;
    cmd[2*idx +: 2]   = c;
    mask[W*idx +: W]  = m;
    step();
    check({tag, "_grant"}, 32'(grant), 32'(expg));
    step();
    step();
    check({tag, "_q"}, 32'(q), 32'(expq));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  logic [NREQ-1:0] cont_g [5];
  logic [W-1:0]    cont_q [5];

  initial begin
    rst       = 1'b1;
    req       = '0;
    cmd       = '0;
    mask      = '0;
    auto_drop = 1'b1;
    for (int i = 0; i < NREQ; i++) cool[i] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    rst = 1'b0;

    run_cmd(0, CMD_SET, 8'h0F, 8'h0F, 4'b0001, "set");
    run_cmd(1, CMD_TGL, 8'hFF, 8'hF0, 4'b0010, "tgl");
    run_cmd(2, CMD_RST, 8'h30, 8'hC0, 4'b0100, "clr");
    run_cmd(3, CMD_HOLD, 8'hFF, 8'hC0, 4'b1000, "hold");

    // Async reset in the middle of APPLY drops the in-flight set.
    req[0]       = 1'b1;
    cmd[1:0]     = CMD_SET;
    mask[W-1:0]  = 8'hFF;
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_q", 32'(q), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    repeat (3) step();
    check("midrst_noupd", 32'(q), 32'd0);

`ifdef JK_ARB_ROUNDROBIN_EN
    cont_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cont_q = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
`else
    cont_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    cont_q = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
`endif
    auto_drop = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cmd[2*i +: 2]  = CMD_TGL;
      mask[W*i +: W] = W'(1) << i;
    end
    req = '1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("cont_grant", 32'(grant), 32'(cont_g[k]));
      if (k > 0) check("cont_q", 32'(q), 32'(cont_q[k-1]));
      step();
    end
    step();
    check("cont_q_last", 32'(q), 32'(cont_q[4]));
    req = '0;
    repeat (3) step();

    auto_drop = 1'b1;
    for (int i = 0; i < NREQ; i++) cool[i] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (cool[i] > 0) begin
          cool[i]--;
        end else if (!req[i]) begin
          cmd[2*i +: 2]  = 2'($urandom);
          mask[W*i +: W] = W'($urandom);
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
